// File: rtl/exe_hilo_unit_if.sv
// Decode-to-execute bus for exe_hilo_unit: operation in, registered writeback and HI/LO out.
// master = decode/downstream side, slave = the execute unit.
interface exe_hilo_unit_if;
  logic        valid_i;
  logic        ready_o;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic        stall_i;
  logic        valid_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output valid_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, stall_i,
    input  ready_o, valid_o, wd_o, wreg_o, wdata_o, hi_o, lo_o
  );

  modport slave (
    input  valid_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, stall_i,
    output ready_o, valid_o, wd_o, wreg_o, wdata_o, hi_o, lo_o
  );
endinterface

// File: rtl/exe_hilo_unit.sv
// Logic/shift/move execute stage with HI/LO registers; 1-cycle latency, holds on stall_i, ready_o drops on stall
// or (without HILO_BYPASS_EN) on an MFHI/MFLO read of a still-pending MTHI/MTLO. Define HILO_BYPASS_EN to forward instead.
module exe_hilo_unit (
  input  logic             clk,
  input  logic             rst,
  exe_hilo_unit_if.slave   bus
);
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MOVE  = 3'b011;

  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_MOVZ = 8'h0A;
  localparam logic [7:0] OP_MOVN = 8'h0B;
  localparam logic [7:0] OP_MFHI = 8'h10;
  localparam logic [7:0] OP_MTHI = 8'h11;
  localparam logic [7:0] OP_MFLO = 8'h12;
  localparam logic [7:0] OP_MTLO = 8'h13;

  logic        valid_q;
  logic [4:0]  wd_q;
  logic        wreg_q;
  logic [31:0] wdata_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        pend_hi_q;
  logic        pend_lo_q;

  logic [31:0] res;
  logic        res_wreg;
  logic        set_hi;
  logic        set_lo;
  logic [31:0] eff_hi;
  logic [31:0] eff_lo;
  logic        is_mfhi;
  logic        is_mflo;
  logic        hazard;
  logic        ready;
  logic        xfer;
  logic [4:0]  sh;

  assign is_mfhi = (bus.alusel_i == SEL_MOVE) && (bus.aluop_i == OP_MFHI);
  assign is_mflo = (bus.alusel_i == SEL_MOVE) && (bus.aluop_i == OP_MFLO);

  // A pending MTHI/MTLO lives in wdata_q until it commits.
`ifdef HILO_BYPASS_EN
  assign eff_hi = (valid_q && pend_hi_q) ? wdata_q : hi_q;
  assign eff_lo = (valid_q && pend_lo_q) ? wdata_q : lo_q;
  assign hazard = 1'b0;
`else
  assign eff_hi = hi_q;
  assign eff_lo = lo_q;
  assign hazard = bus.valid_i && valid_q &&
                  ((is_mfhi && pend_hi_q) || (is_mflo && pend_lo_q));
`endif

  assign ready = rst && !bus.stall_i && !hazard;
  assign xfer  = bus.valid_i && ready;
  assign sh    = bus.reg1_i[4:0];

  always_comb begin
    res      = 32'h0;
    res_wreg = bus.wreg_i;
    set_hi   = 1'b0;
    set_lo   = 1'b0;
    case (bus.alusel_i)
      SEL_LOGIC: begin
        case (bus.aluop_i)
          OP_OR:   res = bus.reg1_i | bus.reg2_i;
          OP_AND:  res = bus.reg1_i & bus.reg2_i;
          OP_XOR:  res = bus.reg1_i ^ bus.reg2_i;
          OP_NOR:  res = ~(bus.reg1_i | bus.reg2_i);
          default: res = 32'h0;
        endcase
      end
      SEL_SHIFT: begin
        case (bus.aluop_i)
          OP_SLL:  res = bus.reg2_i << sh;
          OP_SRL:  res = bus.reg2_i >> sh;
          OP_SRA:  res = $unsigned($signed(bus.reg2_i) >>> sh);
          default: res = 32'h0;
        endcase
      end
      SEL_MOVE: begin
        case (bus.aluop_i)
          OP_MOVZ, OP_MOVN: res = bus.reg1_i;
          OP_MFHI: res = eff_hi;
          OP_MFLO: res = eff_lo;
          OP_MTHI: begin
            res      = bus.reg1_i;
            res_wreg = 1'b0;
            set_hi   = 1'b1;
          end
          OP_MTLO: begin
            res      = bus.reg1_i;
            res_wreg = 1'b0;
            set_lo   = 1'b1;
          end
          default: res = 32'h0;
        endcase
      end
      default: res = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      wd_q      <= 5'h0;
      wreg_q    <= 1'b0;
      wdata_q   <= 32'h0;
      hi_q      <= 32'h0;
      lo_q      <= 32'h0;
      pend_hi_q <= 1'b0;
      pend_lo_q <= 1'b0;
    end else if (!bus.stall_i) begin
      // Commit the old pending write before the register is overwritten.
      if (valid_q && pend_hi_q) hi_q <= wdata_q;
      if (valid_q && pend_lo_q) lo_q <= wdata_q;
      if (xfer) begin
        valid_q   <= 1'b1;
        wd_q      <= bus.wd_i;
        wreg_q    <= res_wreg;
        wdata_q   <= res;
        pend_hi_q <= set_hi;
        pend_lo_q <= set_lo;
      end else begin
        valid_q   <= 1'b0;
        wreg_q    <= 1'b0;
        pend_hi_q <= 1'b0;
        pend_lo_q <= 1'b0;
      end
    end
  end

  assign bus.ready_o = ready;
  assign bus.valid_o = valid_q;
  assign bus.wd_o    = wd_q;
  assign bus.wreg_o  = wreg_q;
  assign bus.wdata_o = wdata_q;
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;
endmodule

// File: doc/exe_hilo_unit.md
EXE_HILO_UNIT -- requirements
Module: exe_hilo_unit

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset; rst=0 clears all state immediately, independent of clk.
REQ-003 valid_i  in  1  decoded operation present on the *_i buses.
REQ-004 ready_o  out  1  unit accepts the operation this cycle; transfer occurs when valid_i=1 and ready_o=1.
REQ-005 aluop_i  in  8  operation code: NOP 0x00, OR 0x25, AND 0x24, XOR 0x26, NOR 0x27, SLL 0x7C, SRL 0x02, SRA 0x03, MOVZ 0x0A, MOVN 0x0B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13.
REQ-006 alusel_i  in  3  result class: NOP 000, LOGIC 001, SHIFT 010, MOVE 011.
REQ-007 reg1_i, reg2_i  in  32 each  source operands (register value or immediate).
REQ-008 wd_i  in  5  destination register address; wreg_i  in  1  destination write enable.
REQ-009 stall_i  in  1  downstream stall; output register holds while 1.
REQ-010 valid_o  out  1  output register holds a completed operation.
REQ-011 wd_o  out  5, wreg_o  out  1, wdata_o  out  32  registered writeback information.
REQ-012 hi_o, lo_o  out  32 each  committed HI and LO register contents.

Function
REQ-013 Latency: one cycle; an operation transferred at edge N appears on valid_o/wd_o/wreg_o/wdata_o after edge N.
REQ-014 LOGIC: OR/AND/XOR/NOR of reg1_i and reg2_i, bitwise, 32 bits.
REQ-015 SHIFT: reg2_i shifted by reg1_i[4:0]; SLL/SRL zero-fill, SRA replicates reg2_i[31]; reg1_i[31:5] ignored.
REQ-016 MOVE: MOVZ/MOVN result = reg1_i with wreg_i passed unchanged; MFHI/MFLO result = effective HI/LO (REQ-021).
REQ-017 MTHI/MTLO: wdata_o = reg1_i, wreg_o forced 0; operation carries a pending HI (resp. LO) write.
REQ-018 alusel NOP or unlisted aluop/alusel pair: wdata_o = 0, wreg_o = wreg_i, no HI/LO effect.
REQ-019 Commit: a pending HI/LO write in a valid output register commits at the first edge with stall_i=0; hi_o/lo_o change only then.
REQ-020 Output register update: stall_i=1 -> hold all outputs; stall_i=0 and transfer -> load new result, valid_o=1; stall_i=0 and no transfer -> valid_o=0, wreg_o=0, other outputs don't-care.
REQ-021 Effective HI/LO for MFHI/MFLO = committed value, unless output register holds an uncommitted write to the same register (REQ-024/025).
REQ-022 ready_o = 0 whenever stall_i=1; otherwise per REQ-024/025.
REQ-023 Simultaneous transfer and commit at one edge: new operation's MTHI/MTLO becomes pending; old pending value commits; no loss.

Reset
REQ-026 During rst=0: valid_o=0, wreg_o=0, wd_o=0, wdata_o=0, hi_o=0, lo_o=0, no pending write; ready_o=0.
REQ-027 Reset asserted mid-operation discards any uncommitted HI/LO write; first transfer possible at first edge after rst rises.

Configuration
REQ-024 With macro HILO_BYPASS_EN defined: MFHI/MFLO forwards reg1 value of the pending MTHI/MTLO in the output register; ready_o = !stall_i.
REQ-025 Without HILO_BYPASS_EN: ready_o = 0 while valid_i=1 carries MFHI/MFLO and the output register holds a pending write to the same register; stall lasts exactly until commit (one cycle if stall_i=0), then MFHI/MFLO reads committed value.

Verification
REQ-028 OR reg1=0x0000FF00, reg2=0x00FF00FF, wd=5, wreg=1 -> next cycle valid_o=1, wd_o=5, wdata_o=0x00FFFFFF.
REQ-029 SRA reg1=4, reg2=0x80000010 -> wdata_o=0xF8000001; SLL reg1=0x23 (uses 3), reg2=1 -> wdata_o=0x8.
REQ-030 MTHI reg1=0xDEADBEEF then MFHI back-to-back, wd=2: with HILO_BYPASS_EN wdata_o=0xDEADBEEF one cycle later, no ready_o drop; without it ready_o=0 for one cycle, then wdata_o=0xDEADBEEF, hi_o=0xDEADBEEF.
REQ-031 MTLO reg1=0x1234 with stall_i=1 held 3 cycles -> lo_o stays 0 and outputs hold; lo_o=0x1234 after first edge with stall_i=0.
REQ-032 MTHI 0x55 accepted, rst pulsed low before commit -> hi_o=0, valid_o=0; subsequent MFHI returns 0.
REQ-033 MOVN reg1=0x77, wreg_i=0 -> wdata_o=0x77, wreg_o=0; aluop 0xFF alusel 001 -> wdata_o=0.
